// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request front-end for the SRAM group memory model.
//
// Accepts read/write requests over a valid/ready handshake and drives the
// memory pins combinationally in the accept cycle, at most one access per
// cycle. Read data arrives from the memory one cycle after the accept. It is
// captured into a small response FIFO so the consumer can apply backpressure
// without losing data. Reads are credit-gated: a request is accepted only
// when a response slot is guaranteed.
//
// Ports:
//   clk, rst_n                 clock (shared with memory), async active-low reset
//   req_vld/req_rdy            request handshake
//   req_wr/req_addr/req_wdata/req_wbe   request payload
//   rsp_vld/rsp_rdy/rsp_data   read response handshake and data
//   mem_*                      memory interface (en, addr, wr_en, wr_data,
//                              wr_byte_en, rd_data)
//   busy                       read in flight or response FIFO non-empty
//   perf_rd_cnt/perf_wr_cnt/perf_stall_cnt   saturating event counters
//
// Build option:
//   SRAM_REQ_CTRL_PERF_EN      when defined, the perf_* counters are
//                              implemented; otherwise the ports are tied to 0.

module sram_req_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wbe,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  output logic                    busy,
  output logic [31:0]             perf_rd_cnt,
  output logic [31:0]             perf_wr_cnt,
  output logic [31:0]             perf_stall_cnt
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);
  localparam logic [CW:0]   DEPTH_U  = (CW+1)'(RSP_DEPTH);

  logic                  acc;
  logic                  push;
  logic                  pop;
  logic                  rd_pend_q, rd_pend_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW:0]           used;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

  assign acc  = req_vld & req_rdy;
  assign push = rd_pend_q;
  assign pop  = rsp_vld & rsp_rdy;

  // A read in flight already owns a FIFO slot. A pop in the same cycle frees
  // one, which keeps back-to-back reads at full rate with a full FIFO.
  assign used    = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
  assign req_rdy = (used < DEPTH_U) | pop;

  assign mem_en         = acc;
  assign mem_wr_en      = acc & req_wr;
  assign mem_addr       = req_addr;
  assign mem_wr_data    = req_wdata;
  assign mem_wr_byte_en = req_wbe;

  assign rsp_vld  = (cnt_q != '0);
  assign rsp_data = fifo_q[rd_ptr_q];
  assign busy     = rd_pend_q | rsp_vld;

  always_comb begin
    rd_pend_d = acc & ~req_wr;
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d     = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage is not reset; stale entries are never visible because rsp_vld
  // is derived from the count. Memory data, X included, passes untouched.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_rd_data;
    end
  end

  // Credit accounting makes overflow unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == FULL_CNT) && !pop));

`ifdef SRAM_REQ_CTRL_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (acc && !req_wr && (perf_rd_q != '1)) begin
        perf_rd_q <= perf_rd_q + 32'd1;
      end
      if (acc && req_wr && (perf_wr_q != '1)) begin
        perf_wr_q <= perf_wr_q + 32'd1;
      end
      if (req_vld && !req_rdy && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_rd_cnt    = '0;
  assign perf_wr_cnt    = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed testbench for sram_req_ctrl with a behavioral SRAM model:
// writes commit at the clock edge with byte enables, reads return the
// addressed word registered one cycle later.

module tb_sram_req_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic         req_wr;
  logic [8:0]   req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wbe;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [127:0] rsp_data;
  logic         mem_en;
  logic [8:0]   mem_addr;
  logic         mem_wr_en;
  logic [127:0] mem_wr_data;
  logic [15:0]  mem_wr_byte_en;
  logic [127:0] mem_rd_data;
  logic         busy;
  logic [31:0]  perf_rd_cnt;
  logic [31:0]  perf_wr_cnt;
  logic [31:0]  perf_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int           acc_q[$];
  int           rsp_cyc_q[$];
  logic [127:0] rsp_data_q[$];

  logic [127:0] tb_mem [0:511];

  sram_req_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wbe        (req_wbe),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_data       (rsp_data),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_byte_en (mem_wr_byte_en),
    .mem_rd_data    (mem_rd_data),
    .busy           (busy),
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        for (int b = 0; b < 16; b++) begin
          if (mem_wr_byte_en[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
      end else begin
        mem_rd_data <= tb_mem[mem_addr];
      end
    end
  end

  // Handshake recorder, sampled mid-cycle after the inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (req_vld && req_rdy) acc_q.push_back(cyc);
      if (rsp_vld && rsp_rdy) begin
        rsp_data_q.push_back(rsp_data);
        rsp_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic logic [127:0] pat(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(a);
    return {w, w, w, w};
  endfunction

  task automatic clear_log();
    acc_q.delete();
    rsp_cyc_q.delete();
    rsp_data_q.delete();
  endtask

  task automatic idle();
    req_vld = 1'b0;
    req_wr  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [8:0] a,
                       input logic [127:0] d, input logic [15:0] be);
    int w;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wbe = be;
    w = 0;
    #1;
    while (!req_rdy && w < 50) begin
      @(negedge clk); #1; w++;
    end
    n_cmp++;
    if (!req_rdy) begin
      n_err++;
      $display("FAIL issue_timeout: addr %0h not accepted after %0d cycles", a, w);
    end
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int w;
    w = 0;
    while (rsp_data_q.size() < n && w < budget) begin
      @(negedge clk); w++;
    end
    n_cmp++;
    if (rsp_data_q.size() < n) begin
      n_err++;
      $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_data_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rsp_rdy = 1'b0;
    req_addr = '0; req_wdata = '0; req_wbe = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
    n_cmp++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL reset_rsp_vld: got %b want 0", rsp_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_cmp++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    rsp_rdy = 1'b1;
    clear_log();
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h010; req_wdata = {16{8'hA5}}; req_wbe = 16'hFFFF;
    #1;
    n_cmp++;
    if ({mem_en, mem_wr_en, mem_addr, mem_wr_byte_en} !== {1'b1, 1'b1, 9'h010, 16'hFFFF}) begin
      n_err++;
      $display("FAIL wr_mem_drive: got en=%b we=%b addr=%h be=%h want 1 1 010 ffff",
               mem_en, mem_wr_en, mem_addr, mem_wr_byte_en);
    end
    @(negedge clk);
    req_wr = 1'b0; req_addr = 9'h010;
    #1;
    n_cmp++;
    if ({mem_en, mem_wr_en, mem_addr} !== {1'b1, 1'b0, 9'h010}) begin
      n_err++;
      $display("FAIL rd_mem_drive: got en=%b we=%b addr=%h want 1 0 010", mem_en, mem_wr_en, mem_addr);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL idle_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
    wait_rsp(1, 10);
    if (rsp_data_q.size() >= 1 && acc_q.size() >= 2) begin
      n_cmp++;
      if (rsp_data_q[0] !== {16{8'hA5}}) begin
        n_err++; $display("FAIL wr_rd_data: got %h want %h", rsp_data_q[0], {16{8'hA5}});
      end
      n_cmp++;
      if (rsp_cyc_q[0] - acc_q[1] !== 2) begin
        n_err++; $display("FAIL rd_latency: got %0d want 2", rsp_cyc_q[0] - acc_q[1]);
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drained_busy: got %b want 0", busy); end
  endtask

  task automatic test_byte_enable();
    rsp_rdy = 1'b1;
    clear_log();
    issue(1'b1, 9'h020, 128'd0, 16'hFFFF);
    issue(1'b1, 9'h020, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'h0001);
    issue(1'b0, 9'h020, 128'd0, 16'h0000);
    idle();
    wait_rsp(1, 10);
    if (rsp_data_q.size() >= 1) begin
      n_cmp++;
      if (rsp_data_q[0] !== 128'h0000_0000_0000_0000_0000_0000_0000_00FF) begin
        n_err++; $display("FAIL byte_enable_data: got %h want 000000ff", rsp_data_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_rdy = 1'b1;
    for (int a = 0; a < 8; a++) issue(1'b1, 9'(a), pat(a), 16'hFFFF);
    idle();
    clear_log();
    for (int a = 0; a < 8; a++) issue(1'b0, 9'(a), 128'd0, 16'h0000);
    idle();
    wait_rsp(8, 20);
    n_cmp++;
    if (acc_q.size() !== 8) begin
      n_err++; $display("FAIL b2b_accepts: got %0d want 8", acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[7] - acc_q[0] !== 7) begin
        n_err++; $display("FAIL b2b_accept_rate: span %0d want 7", acc_q[7] - acc_q[0]);
      end
      if (rsp_data_q.size() >= 8) begin
        n_cmp++;
        if (rsp_cyc_q[0] - acc_q[0] !== 2) begin
          n_err++; $display("FAIL b2b_first_latency: got %0d want 2", rsp_cyc_q[0] - acc_q[0]);
        end
        n_cmp++;
        if (rsp_cyc_q[7] - rsp_cyc_q[0] !== 7) begin
          n_err++; $display("FAIL b2b_rsp_rate: span %0d want 7", rsp_cyc_q[7] - rsp_cyc_q[0]);
        end
        for (int i = 0; i < 8; i++) begin
          n_cmp++;
          if (rsp_data_q[i] !== pat(i)) begin
            n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rsp_data_q[i], pat(i));
          end
        end
      end
    end
  endtask

  task automatic test_credit();
    rsp_rdy = 1'b0;
    clear_log();
    issue(1'b0, 9'h000, 128'd0, 16'h0000);
    issue(1'b0, 9'h001, 128'd0, 16'h0000);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h002;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (req_rdy !== 1'b0) begin n_err++; $display("FAIL credit_stall[%0d]: req_rdy got %b want 0", i, req_rdy); end
      n_cmp++;
      if (rsp_data !== pat(0) || rsp_vld !== 1'b1) begin
        n_err++; $display("FAIL credit_head_stable[%0d]: vld=%b data=%h want 1 %h", i, rsp_vld, rsp_data, pat(0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (acc_q.size() !== 2) begin n_err++; $display("FAIL credit_accepts: got %0d want 2", acc_q.size()); end
    rsp_rdy = 1'b1;
    #1;
    n_cmp++;
    if (req_rdy !== 1'b1) begin n_err++; $display("FAIL credit_pop_rdy: got %b want 1", req_rdy); end
    @(negedge clk);
    issue(1'b0, 9'h003, 128'd0, 16'h0000);
    idle();
    wait_rsp(4, 20);
    n_cmp++;
    if (acc_q.size() !== 4) begin n_err++; $display("FAIL credit_total_accepts: got %0d want 4", acc_q.size()); end
    if (rsp_data_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rsp_data_q[i] !== pat(i)) begin
          n_err++; $display("FAIL credit_order[%0d]: got %h want %h", i, rsp_data_q[i], pat(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    rsp_rdy = 1'b0;
    issue(1'b0, 9'h004, 128'd0, 16'h0000);
    issue(1'b0, 9'h005, 128'd0, 16'h0000);
    idle();
    #1;
    n_cmp++;
    if ({busy, rsp_vld} !== 2'b11) begin
      n_err++; $display("FAIL pre_reset_state: busy=%b rsp_vld=%b want 1 1", busy, rsp_vld);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_vld, busy, req_rdy} !== 3'b001) begin
      n_err++; $display("FAIL mid_reset_outputs: rsp_vld=%b busy=%b req_rdy=%b want 0 0 1", rsp_vld, busy, req_rdy);
    end
    @(negedge clk);
    @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (rsp_data_q.size() !== 0) begin
      n_err++; $display("FAIL post_reset_rsp: got %0d responses want 0", rsp_data_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_perf();
    logic [95:0] exp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    clear_log();
    issue(1'b1, 9'h040, pat(64), 16'hFFFF);
    issue(1'b1, 9'h041, pat(65), 16'hFFFF);
    rsp_rdy = 1'b0;
    issue(1'b0, 9'h040, 128'd0, 16'h0000);
    issue(1'b0, 9'h041, 128'd0, 16'h0000);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h040;
    repeat (5) @(negedge clk);
    rsp_rdy = 1'b1;
    @(negedge clk);
    idle();
    wait_rsp(3, 20);
    if (rsp_data_q.size() >= 3) begin
      n_cmp++;
      if (rsp_data_q[1] !== pat(65) || rsp_data_q[2] !== pat(64)) begin
        n_err++; $display("FAIL perf_rsp_data: got %h %h want %h %h", rsp_data_q[1], rsp_data_q[2], pat(65), pat(64));
      end
    end
`ifdef SRAM_REQ_CTRL_PERF_EN
    exp = {32'd3, 32'd2, 32'd5};
`else
    exp = 96'd0;
`endif
    n_cmp++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== exp) begin
      n_err++;
      $display("FAIL perf_counts: got rd=%0d wr=%0d stall=%0d want rd=%0d wr=%0d stall=%0d",
               perf_rd_cnt, perf_wr_cnt, perf_stall_cnt, exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rsp_rdy = 1'b0;
    req_addr = '0; req_wdata = '0; req_wbe = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_credit();
    test_reset_mid_op();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
